dmem_responder: RTL and testbench

Data-memory responder for the pipelined RISC-V core: it serves the load/store requests issued by the memory stage and returns read data for write-back. Internally it holds word-addressed storage behind a small request/response state machine with a programmable number of wait states. It drives a stall signal back to the pipeline while an access is in flight.

---
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_responder.sv | 132 +++++++++++++
 tb/tb_dmem_responder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the pipeline memory stage (master) and dmem_responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;

    // A request transfers on the rising edge where req_valid && req_ready; the master then
    // holds the request stable until the one-cycle resp_valid pulse that completes it.
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_rdata, resp_err, stall
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with IDLE/WAIT/RESP access FSM and LATENCY wait states.
// Optional macro DMEM_BOUNDS_CHECK_EN: flag out-of-range accesses instead of wrapping the address.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_responder_if.slave  bus,
    output logic [1:0]       dbg_state
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t         state;
    logic [3:0]     cnt;
    logic           lat_write;
    logic [AW-1:0]  lat_idx;
    logic [31:0]    lat_wdata;
    logic [3:0]     lat_wstrb;
    logic           lat_oor;
    logic           resp_valid_q;
    logic [31:0]    rdata_q;
    logic           err_q;
    logic [31:0]    mem [DEPTH_WORDS];

    logic           in_oor;
    logic           commit;
    logic           c_write;
    logic [AW-1:0]  c_idx;
    logic [31:0]    c_wdata;
    logic [3:0]     c_wstrb;
    logic           c_oor;
    logic           unused_bits;

`ifdef DMEM_BOUNDS_CHECK_EN
    assign in_oor       = ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign bus.resp_err = err_q;
    assign unused_bits  = ^bus.req_addr[1:0];
`else
    assign in_oor       = 1'b0;
    assign bus.resp_err = 1'b0;
    assign unused_bits  = ^{bus.req_addr[1:0], bus.req_addr[31:AW+2], err_q};
`endif

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.stall      = bus.req_valid && !resp_valid_q;
    assign dbg_state      = state;

    // With zero wait states the access commits on the acceptance edge straight from the bus.
    always_comb begin
        commit  = 1'b0;
        c_write = lat_write;
        c_idx   = lat_idx;
        c_wdata = lat_wdata;
        c_wstrb = lat_wstrb;
        c_oor   = lat_oor;
        if (state == ST_IDLE && LATENCY == 0) begin
            commit  = bus.req_valid;
            c_write = bus.req_write;
            c_idx   = bus.req_addr[AW+1:2];
            c_wdata = bus.req_wdata;
            c_wstrb = bus.req_wstrb;
            c_oor   = in_oor;
        end else if (state == ST_WAIT && cnt == 4'd1) begin
            commit = 1'b1;
        end
    end

    // Storage is deliberately not reset; rst_n gates a commit racing an asserted reset.
    always_ff @(posedge clk) begin
        if (rst_n && commit && c_write && !c_oor) begin
            for (int b = 0; b < 4; b++) begin
                if (c_wstrb[b]) begin
                    mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= 4'd0;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'h0;
            err_q        <= 1'b0;
            lat_write    <= 1'b0;
            lat_idx      <= '0;
            lat_wdata    <= 32'h0;
            lat_wstrb    <= 4'h0;
            lat_oor      <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'h0;
            err_q        <= 1'b0;
            if (commit) begin
                resp_valid_q <= 1'b1;
                rdata_q      <= (c_write || c_oor) ? 32'h0 : mem[c_idx];
                err_q        <= c_oor;
            end
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        lat_write <= bus.req_write;
                        lat_idx   <= bus.req_addr[AW+1:2];
                        lat_wdata <= bus.req_wdata;
                        lat_wstrb <= bus.req_wstrb;
                        lat_oor   <= in_oor;
                        cnt       <= 4'(LATENCY);
                        state     <= (LATENCY == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with LATENCY=2 and one with LATENCY=0, checked every cycle
// against a transaction-level memory model plus literal expectations from hand-worked cases.
module tb_dmem_responder;
    localparam int NI    = 2;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req_valid [NI];
    logic        req_write [NI];
    logic [31:0] req_addr  [NI];
    logic [31:0] req_wdata [NI];
    logic [3:0]  req_wstrb [NI];
    wire         req_ready  [NI];
    wire         resp_valid [NI];
    wire  [31:0] resp_rdata [NI];
    wire         resp_err   [NI];
    wire         stall      [NI];
    wire  [1:0]  dbg_state  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_responder_if bus ();
        assign bus.req_valid  = req_valid[g];
        assign bus.req_write  = req_write[g];
        assign bus.req_addr   = req_addr[g];
        assign bus.req_wdata  = req_wdata[g];
        assign bus.req_wstrb  = req_wstrb[g];
        assign req_ready[g]   = bus.req_ready;
        assign resp_valid[g]  = bus.resp_valid;
        assign resp_rdata[g]  = bus.resp_rdata;
        assign resp_err[g]    = bus.resp_err;
        assign stall[g]       = bus.stall;
        dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(g == 0 ? 2 : 0)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .bus       (bus),
            .dbg_state (dbg_state[g])
        );
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    // Model: word memory per instance plus the single outstanding transaction's timeline.
    logic [31:0] mdl_mem [NI][DEPTH];
    logic        pend       [NI];
    int          pend_acc   [NI];
    int          pend_resp  [NI];
    logic [31:0] pend_rdata [NI];
    logic        pend_err   [NI];
    logic        chk_en = 1'b0;
    int          stall_cnt    [NI];
    int          obs_acc      [NI];
    int          obs_acc_prev [NI];
    int          obs_resp     [NI];
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin : cmp
        logic ev;
        logic exp_ready;
        if (rst_n && chk_en) begin
            for (int i = 0; i < NI; i++) begin
                ev        = pend[i] && (cyc == pend_resp[i]);
                exp_ready = !(pend[i] && cyc >= pend_acc[i] && cyc <= pend_resp[i]);
                check($sformatf("resp_valid[%0d]", i), 32'(resp_valid[i]), 32'(ev));
                check($sformatf("resp_rdata[%0d]", i), resp_rdata[i], ev ? pend_rdata[i] : 32'h0);
                check($sformatf("resp_err[%0d]", i), 32'(resp_err[i]), ev ? 32'(pend_err[i]) : 32'h0);
                check($sformatf("stall[%0d]", i), 32'(stall[i]), 32'(req_valid[i] && !ev));
                check($sformatf("req_ready[%0d] state=%0d", i, dbg_state[i]), 32'(req_ready[i]),
                      32'(exp_ready));
                if (stall[i]) stall_cnt[i]++;
                if (req_valid[i] && req_ready[i]) begin
                    obs_acc_prev[i] = obs_acc[i];
                    obs_acc[i]      = cyc + 1;
                end
                if (resp_valid[i]) obs_resp[i] = cyc;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the response.
    task automatic xact(input int i, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic perturb, output logic [31:0] got);
        int          idx;
        logic        oor;
        logic [31:0] w;
        idx = int'((addr >> 2) % 32'(DEPTH));
        oor = 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
        oor = (addr >> 2) >= 32'(DEPTH);
`endif
        w             = mdl_mem[i][idx];
        pend_err[i]   = oor;
        pend_rdata[i] = (wr || oor) ? 32'h0 : w;
        if (wr && !oor) begin
            for (int b = 0; b < 4; b++) if (wstrb[b]) w[8*b +: 8] = wdata[8*b +: 8];
            mdl_mem[i][idx] = w;
        end
        req_write[i]  = wr;
        req_addr[i]   = addr;
        req_wdata[i]  = wdata;
        req_wstrb[i]  = wstrb;
        req_valid[i]  = 1'b1;
        pend_acc[i]   = cyc + 1;
        pend_resp[i]  = pend_acc[i] + lat_of(i);
        pend[i]       = 1'b1;
        got           = 'x;
        for (int k = 0; k < 40 && cyc <= pend_resp[i]; k++) begin
            @(posedge clk);
            #1;
            if (perturb && cyc == pend_acc[i]) begin
                req_addr[i]  = req_addr[i] ^ 32'h40;
                req_wdata[i] = ~wdata;
                req_wstrb[i] = ~wstrb;
            end
            if (cyc == pend_resp[i]) got = resp_rdata[i];
        end
        req_valid[i] = 1'b0;
        pend[i]      = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] got;
        for (int i = 0; i < NI; i++) begin
            req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = 32'h0;
            req_wdata[i] = 32'h0; req_wstrb[i] = 4'h0; pend[i] = 1'b0;
            pend_acc[i] = 0; pend_resp[i] = 0; pend_rdata[i] = 32'h0; pend_err[i] = 1'b0;
            stall_cnt[i] = 0; obs_acc[i] = 0; obs_acc_prev[i] = 0; obs_resp[i] = 0;
            for (int w = 0; w < DEPTH; w++) mdl_mem[i][w] = 32'h0;
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_resp_valid[%0d]", i), 32'(resp_valid[i]), 32'h0);
            check($sformatf("rst_rdata[%0d]", i), resp_rdata[i], 32'h0);
            check($sformatf("rst_err[%0d]", i), 32'(resp_err[i]), 32'h0);
            check($sformatf("rst_ready[%0d]", i), 32'(req_ready[i]), 32'h1);
            check($sformatf("rst_stall[%0d]", i), 32'(stall[i]), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Word store then load, three cycles of stall per access.
        stall_cnt[0] = 0;
        xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, got);
        check("store_rdata_zero", got, 32'h0);
        check("store_stall_cycles", 32'(stall_cnt[0]), 32'd3);
        check("l2_resp_after_accept", 32'(obs_resp[0] - obs_acc[0]), 32'd2);
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, got);
        check("load_word", got, 32'hDEADBEEF);

        // Byte strobes on lanes 0 and 2.
        xact(0, 1'b1, 32'h14, 32'h11223344, 4'hF, 1'b0, got);
        xact(0, 1'b1, 32'h14, 32'hAABBCCDD, 4'b0101, 1'b0, got);
        xact(0, 1'b0, 32'h14, 32'h0, 4'h0, 1'b0, got);
        check("strobe_merge", got, 32'h11BB33DD);

        // Zero wait states, back-to-back loads.
        xact(1, 1'b1, 32'h0, 32'h0A0A0A0A, 4'hF, 1'b0, got);
        xact(1, 1'b1, 32'h4, 32'h0B0B0B0B, 4'hF, 1'b0, got);
        xact(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, got);
        check("l0_load_0", got, 32'h0A0A0A0A);
        check("l0_resp_after_accept", 32'(obs_resp[1] - obs_acc[1]), 32'd0);
        xact(1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0, got);
        check("l0_load_4", got, 32'h0B0B0B0B);
        check("l0_accept_spacing", 32'(obs_acc[1] - obs_acc_prev[1]), 32'd2);

        // Out-of-range address 0x1000.
        xact(0, 1'b1, 32'h0, 32'h01020304, 4'hF, 1'b0, got);
        xact(0, 1'b1, 32'h1000, 32'h5A5A5A5A, 4'hF, 1'b0, got);
        xact(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, got);
`ifdef DMEM_BOUNDS_CHECK_EN
        check("oor_store_blocked", got, 32'h01020304);
        xact(0, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b0, got);
        check("oor_load_rdata", got, 32'h0);
`else
        check("oor_store_wraps", got, 32'h5A5A5A5A);
        xact(0, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b0, got);
        check("oor_load_wraps", got, 32'h5A5A5A5A);
`endif

        // Request inputs changed after acceptance are ignored.
        xact(0, 1'b1, 32'h30, 32'h77778888, 4'hF, 1'b1, got);
        xact(0, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0, got);
        check("hold_store", got, 32'h77778888);
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, got);
        check("hold_load", got, 32'hDEADBEEF);

        // Reset one cycle after accepting a store: store is abandoned.
        xact(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0, got);
        chk_en = 1'b0;
        req_write[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'h12345678;
        req_wstrb[0] = 4'hF; req_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        check("midop_busy", 32'(req_ready[0]), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid[0] = 1'b0;
        #1;
        check("midop_rst_resp_valid", 32'(resp_valid[0]), 32'h0);
        check("midop_rst_rdata", resp_rdata[0], 32'h0);
        check("midop_rst_ready", 32'(req_ready[0]), 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        xact(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, got);
        check("midop_store_abandoned", got, 32'hCAFEF00D);

        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
